// File: rtl/dsp_addsub_seq_if.sv
// Request/result bus of the slice-serial add/subtract unit.
interface dsp_addsub_seq_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  // Requester / result consumer side.
  modport master (
    output in_valid, op, input1, input2, out_ready,
    input  in_ready, out_valid, out, carry_out, overflow, zero
  );

  // Arithmetic unit side.
  modport slave (
    input  in_valid, op, input1, input2, out_ready,
    output in_ready, out_valid, out, carry_out, overflow, zero
  );
endinterface

// File: rtl/dsp_addsub_seq.sv
// Slice-serial WIDTH-bit adder/subtractor: one SLICE-bit lane add per cycle, LSB slice first,
// with the lane carry held in a register between cycles.
module dsp_addsub_seq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 16
) (
  input logic             clk,
  input logic             rst,
  dsp_addsub_seq_if.slave bus
);

  localparam int unsigned SAFE_SLICE = (SLICE == 0) ? 1 : SLICE;
  localparam int unsigned NSLICE     = WIDTH / SAFE_SLICE;
  localparam int unsigned CW         = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned SW         = SLICE + 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

  if ((SLICE == 0) || (WIDTH == 0) || ((WIDTH % SAFE_SLICE) != 0)) begin : g_bad_cfg
    $error("dsp_addsub_seq: WIDTH must be a nonzero multiple of SLICE");
  end

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;
  logic             z_q, z_d;

  int unsigned      base;
  logic [WIDTH-1:0] b_eff;
  logic [SLICE-1:0] a_s, b_s;
  logic [SW-1:0]    sum;
  logic [WIDTH-1:0] res_new;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      z_q     <= z_d;
    end
  end

  // Slice datapath plus next-state logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    res_d   = res_q;
    co_d    = co_q;
    ov_d    = ov_q;
    z_d     = z_q;

    // Subtract is a + ~b + 1; the +1 enters as the initial carry.
    base    = 32'(cnt_q) * SLICE;
    b_eff   = op_q ? ~b_q : b_q;
    a_s     = SLICE'(a_q >> base);
    b_s     = SLICE'(b_eff >> base);
    sum     = {1'b0, a_s} + {1'b0, b_s} + SW'(carry_q);
    res_new = (res_q & ~(SLICE_MASK << base)) | (WIDTH'(sum[SLICE-1:0]) << base);

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.input1;
          b_d     = bus.input2;
          op_d    = bus.op;
          cnt_d   = '0;
          carry_d = bus.op;
          state_d = StCalc;
        end
      end
      StCalc: begin
        res_d   = res_new;
        carry_d = sum[SLICE];
        if (cnt_q == CW'(NSLICE - 1)) begin
          state_d = StDone;
          co_d    = sum[SLICE];
          ov_d    = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (res_new[WIDTH-1] != a_q[WIDTH-1]);
          z_d     = (res_new == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out       = res_q;
  assign bus.carry_out = co_q;
  assign bus.overflow  = ov_q;
  assign bus.zero      = z_q;

endmodule

// File: tb/tb_dsp_addsub_seq.sv
// Self-checking bench for dsp_addsub_seq: 64/16 main instance plus a 16/16 single-slice instance.
module tb_dsp_addsub_seq;

  typedef struct packed {
    logic [63:0] out;
    logic        carry;
    logic        ovf;
    logic        zero;
  } res_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  res_t sb[$];

  dsp_addsub_seq_if #(.WIDTH(64)) bus64 ();
  dsp_addsub_seq_if #(.WIDTH(16)) bus16 ();

  dsp_addsub_seq #(.WIDTH(64), .SLICE(16)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64)
  );

  dsp_addsub_seq #(.WIDTH(16), .SLICE(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: carry and overflow derived from unsigned compare and exact signed math.
  function automatic res_t model(input logic op, input logic [63:0] a, input logic [63:0] b);
    res_t               r;
    logic [64:0]        wide;
    logic signed [65:0] exact;
    if (!op) begin
      wide    = {1'b0, a} + {1'b0, b};
      r.out   = wide[63:0];
      r.carry = wide[64];
      exact   = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
    end else begin
      r.out   = a - b;
      r.carry = (a >= b);
      exact   = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
    end
    r.ovf  = !((exact[65:63] == 3'b000) || (exact[65:63] == 3'b111));
    r.zero = (r.out == 64'd0);
    return r;
  endfunction

  task automatic start_op64(input logic op, input logic [63:0] a, input logic [63:0] b);
    int guard;
    guard = 0;
    while (!bus64.in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    checks++;
    if (!bus64.in_ready) begin
      failures++;
      $display("FAIL start_timeout in_ready=%0b required=1", bus64.in_ready);
    end
    bus64.op       = op;
    bus64.input1   = a;
    bus64.input2   = b;
    bus64.in_valid = 1'b1;
    sb.push_back(model(op, a, b));
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
  endtask

  task automatic wait_done64(output int lat);
    lat = 0;
    while (!bus64.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL latency got=%0d required=4", lat);
    end
  endtask

  task automatic compare64(input string name);
    res_t e;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard_empty", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (bus64.out !== e.out) begin
      failures++;
      $display("FAIL %s out got=%h required=%h", name, bus64.out, e.out);
    end
    checks++;
    if (bus64.carry_out !== e.carry) begin
      failures++;
      $display("FAIL %s carry_out got=%b required=%b", name, bus64.carry_out, e.carry);
    end
    checks++;
    if (bus64.overflow !== e.ovf) begin
      failures++;
      $display("FAIL %s overflow got=%b required=%b", name, bus64.overflow, e.ovf);
    end
    checks++;
    if (bus64.zero !== e.zero) begin
      failures++;
      $display("FAIL %s zero got=%b required=%b", name, bus64.zero, e.zero);
    end
  endtask

  task automatic finish_op64(input string name);
    bus64.out_ready = 1'b1;
    @(posedge clk); #1;
    bus64.out_ready = 1'b0;
    checks++;
    if (bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s handshake out_valid=%b in_ready=%b required 0/1", name,
               bus64.out_valid, bus64.in_ready);
    end
  endtask

  task automatic run_op64(input string name, input logic op, input logic [63:0] a,
                          input logic [63:0] b);
    int lat;
    start_op64(op, a, b);
    wait_done64(lat);
    compare64(name);
    finish_op64(name);
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    bus64.in_valid  = 1'b0;
    bus64.out_ready = 1'b0;
    bus64.op        = 1'b0;
    bus64.input1    = '0;
    bus64.input2    = '0;
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b0;
    bus16.op        = 1'b0;
    bus16.input1    = '0;
    bus16.input2    = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus64.out, bus64.carry_out, bus64.overflow, bus64.zero, bus64.out_valid} !== '0 ||
        bus64.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state out=%h flags=%b%b%b ov=%b ir=%b required all 0, ir=1",
               bus64.out, bus64.carry_out, bus64.overflow, bus64.zero, bus64.out_valid,
               bus64.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    // First edge after reset release must accept.
    bus64.op       = 1'b0;
    bus64.input1   = 64'd1;
    bus64.input2   = 64'd2;
    bus64.in_valid = 1'b1;
    sb.push_back(model(1'b0, 64'd1, 64'd2));
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
    checks++;
    if (bus64.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL first_accept in_ready=%b required=0", bus64.in_ready);
    end
    begin
      int lat;
      wait_done64(lat);
    end
    compare64("first_op");
    finish_op64("first_op");
  endtask

  task automatic test_sub_basic();
    int lat;
    start_op64(1'b1, 64'd5, 64'd3);
    wait_done64(lat);
    checks++;
    if (bus64.out !== 64'd2 || bus64.carry_out !== 1'b1 || bus64.overflow !== 1'b0 ||
        bus64.zero !== 1'b0) begin
      failures++;
      $display("FAIL sub_5_3 out=%h c=%b v=%b z=%b required 2/1/0/0", bus64.out,
               bus64.carry_out, bus64.overflow, bus64.zero);
    end
    compare64("sub_5_3");
    finish_op64("sub_5_3");
  endtask

  task automatic test_edges();
    run_op64("sub_0_1", 1'b1, 64'd0, 64'd1);
    run_op64("sub_x_x", 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
    run_op64("add_max_1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    run_op64("add_slice_carry", 1'b0, 64'h0000_0000_0000_FFFF, 64'd1);
    run_op64("add_ovf", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    run_op64("sub_ovf", 1'b1, 64'h8000_0000_0000_0000, 64'd1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_op64("random", 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
    end
  endtask

  task automatic test_hold();
    int   lat;
    res_t e;
    start_op64(1'b0, 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444);
    e = sb[0];
    wait_done64(lat);
    for (int i = 0; i < 5; i++) begin
      bus64.in_valid = 1'($urandom_range(0, 1));
      bus64.op       = ~bus64.op;
      bus64.input1   = {$urandom, $urandom};
      bus64.input2   = {$urandom, $urandom};
      @(posedge clk); #1;
      checks++;
      if (bus64.out !== e.out || bus64.carry_out !== e.carry || bus64.overflow !== e.ovf ||
          bus64.zero !== e.zero || bus64.in_ready !== 1'b0 || bus64.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL hold cycle=%0d out=%h required=%h ir=%b ov=%b", i, bus64.out, e.out,
                 bus64.in_ready, bus64.out_valid);
      end
    end
    bus64.in_valid = 1'b0;
    compare64("hold");
    finish_op64("hold");
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    run_op64("b2b_a", 1'b0, 64'd100, 64'd200);
    // Ready again right after handshake: next accept is one edge later.
    start_op64(1'b1, 64'd200, 64'd300);
    wait_done64(lat);
    compare64("b2b_b");
    finish_op64("b2b_b");
    gap = 0;
    bus64.out_ready = 1'b1;  // out_ready outside DONE must not matter
    start_op64(1'b0, 64'hFFFF, 64'hFFFF_0000);
    bus64.out_ready = 1'b0;
    wait_done64(gap);
    compare64("ready_early");
    finish_op64("ready_early");
  endtask

  task automatic test_reset_abort();
    res_t dummy;
    start_op64(1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus64.out, bus64.carry_out, bus64.overflow, bus64.zero, bus64.out_valid} !== '0 ||
        bus64.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_abort out=%h ov=%b ir=%b required 0/0/1", bus64.out,
               bus64.out_valid, bus64.in_ready);
    end
    dummy = sb.pop_back();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus64.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_valid cycle=%0d out_valid=%b required=0", i, bus64.out_valid);
      end
    end
  endtask

  task automatic test_width16();
    int lat;
    lat = 0;
    bus16.op       = 1'b1;
    bus16.input1   = 16'h8000;
    bus16.input2   = 16'h0001;
    bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    while (!bus16.out_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != 1) begin
      failures++;
      $display("FAIL w16_latency got=%0d required=1", lat);
    end
    checks++;
    if (bus16.out !== 16'h7FFF || bus16.overflow !== 1'b1 || bus16.carry_out !== 1'b1 ||
        bus16.zero !== 1'b0) begin
      failures++;
      $display("FAIL w16_sub out=%h v=%b c=%b z=%b required 7fff/1/1/0", bus16.out,
               bus16.overflow, bus16.carry_out, bus16.zero);
    end
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    checks++;
    if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL w16_handshake ov=%b ir=%b required 0/1", bus16.out_valid, bus16.in_ready);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_sub_basic();
    test_edges();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    test_width16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsp_addsub_seq.md
DSP_ADDSUB_SEQ -- requirements
Module: dsp_addsub_seq

Interface
REQ-001 Parameter WIDTH, default 64: operand and result width in bits.
REQ-002 Parameter SLICE, default 16: bits processed per cycle, matching the DSP 16-bit adder lane.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request carries valid operands and op.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  1  0 = add (input1 + input2), 1 = subtract (input1 - input2).
REQ-008 input1  input  WIDTH  minuend or first addend.
REQ-009 input2  input  WIDTH  subtrahend or second addend.
REQ-010 out_valid  output  1  out and the flags hold a completed result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 carry_out  output  1  add: carry out of bit WIDTH-1; sub: 1 iff input1 >= input2 unsigned (no borrow).
REQ-014 overflow  output  1  two's-complement signed overflow of the selected operation.
REQ-015 zero  output  1  out == 0.

Function
REQ-016 WIDTH SHALL be a nonzero multiple of SLICE; NSLICE = WIDTH/SLICE; a violation SHALL be an elaboration error.
REQ-017 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE.
REQ-019 An accept is an edge where in_valid=1 and in_ready=1; on an accept the block SHALL latch input1, input2 and op, clear the slice counter and enter CALC.
REQ-020 Subtraction SHALL be computed as input1 + ~input2 + 1, with the initial carry-in = op.
REQ-021 Each CALC edge SHALL compute one SLICE-bit slice, least significant first, using the registered carry from the previous slice, and SHALL write that slice into the result register.
REQ-022 After the NSLICE-th CALC edge the FSM SHALL enter DONE, so out_valid rises exactly NSLICE cycles after the accept edge.
REQ-023 On entry to DONE, carry_out SHALL be the final slice carry.
REQ-024 On entry to DONE, overflow SHALL be (sign of input1 == sign of effective input2) and (sign of out != sign of input1), where the effective input2 is ~input2 for subtract.
REQ-025 On entry to DONE, zero SHALL be (out == 0).
REQ-026 In DONE, out_valid SHALL be 1, and out and the flags SHALL hold stable until a handshake edge with out_ready=1.
REQ-027 On that handshake edge the FSM SHALL return to IDLE and out_valid SHALL fall.
REQ-028 in_valid SHALL be ignored in CALC and DONE, and op and operand changes there SHALL NOT affect the result.
REQ-029 out SHALL change only during CALC; its value during CALC is don't-care to consumers.
REQ-030 Throughput SHALL be at most one operation per NSLICE+2 cycles.
REQ-031 With NSLICE=1 the block SHALL spend one cycle in CALC and then go to DONE.
REQ-032 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-033 While rst=1, state SHALL be IDLE, and out, carry_out, overflow, zero, out_valid and the slice counter SHALL be 0, with in_ready=1; this SHALL take effect immediately, without waiting for a clock edge.
REQ-034 Reset asserted during CALC or DONE SHALL abort the operation and discard the result; no out_valid pulse SHALL follow.
REQ-035 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification (WIDTH=64, SLICE=16 unless stated)
REQ-036 sub 5 - 3 -> out=2, carry_out=1, overflow=0, zero=0, with out_valid exactly 4 cycles after the accept.
REQ-037 sub 0 - 1 -> out=0xFFFF_FFFF_FFFF_FFFF, carry_out=0, overflow=0; sub X - X -> out=0, zero=1, carry_out=1.
REQ-038 add 0xFFFF_FFFF_FFFF_FFFF + 1 -> out=0, carry_out=1, zero=1; add 0x0000_0000_0000_FFFF + 1 -> out=0x1_0000, carrying across the slice boundary.
REQ-039 add 0x7FFF_FFFF_FFFF_FFFF + 1 -> out=0x8000_0000_0000_0000, overflow=1; sub 0x8000_0000_0000_0000 - 1 -> overflow=1.
REQ-040 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and the operands -> out and the flags stay stable and in_ready stays 0; raising out_ready -> IDLE on the next edge.
REQ-041 Assert rst 2 cycles into CALC -> all outputs 0 and in_ready=1 at once, with no out_valid; then with WIDTH=16, SLICE=16, sub 0x8000 - 1 -> out=0x7FFF, overflow=1, 1-cycle latency.
